// File: rtl/lbp_host.sv
// ---------------------------------------------------------------------------
// lbp_host
//
// Host-side memory wrapper for a local-binary-pattern engine. It first
// receives a 128x128 8-bit grayscale image as a raster stream. It then serves
// pixel reads to the engine and captures the result bytes the engine writes
// back. After the engine signals the end of the image, it exposes the result
// store for readout.
//
// State flow: LOAD -> SERVE -> DONE. DONE is left only through reset.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset (control/outputs only)
//   in_valid    in   1   image-load strobe, one pixel per cycle
//   in_data     in   8   load pixel, raster order starting at address 0
//   gray_addr   in  14   engine read address {row[6:0], col[6:0]}
//   gray_req    in   1   engine read request
//   gray_ready  out  1   image fully loaded (high only in SERVE)
//   gray_data   out  8   registered image read data, one-cycle latency
//   lbp_addr    in  14   result write address
//   lbp_valid   in   1   result write strobe
//   lbp_data    in   8   result byte
//   finish      in   1   end-of-image flag from the engine
//   rd_addr     in  14   result readout address (DONE)
//   rd_data     out  8   registered result readout data, one-cycle latency
//   done        out  1   high in DONE
//   wr_count    out 15   accepted result writes, saturating at 16384
// ---------------------------------------------------------------------------
module lbp_host (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic [13:0] gray_addr,
    input  logic        gray_req,
    output logic        gray_ready,
    output logic [7:0]  gray_data,
    input  logic [13:0] lbp_addr,
    input  logic        lbp_valid,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    input  logic [13:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic [14:0] wr_count
);

    localparam int          DEPTH  = 16384;
    localparam logic [13:0] LAST_PIX = 14'h3FFF;
    localparam logic [14:0] WR_MAX = 15'd16384;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] ld_cnt_q, ld_cnt_d;
    logic [14:0] wr_count_q, wr_count_d;
    logic [7:0]  gray_data_q;
    logic [7:0]  rd_data_q;

    logic        img_we;
    logic        res_we;
    logic        gray_rd_en;
    logic        res_rd_en;

    // Storage arrays carry no reset: their contents survive reset.
    logic [7:0]  img [DEPTH];
    logic [7:0]  res [DEPTH];

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        wr_count_d = wr_count_q;
        img_we     = 1'b0;
        res_we     = 1'b0;
        gray_rd_en = 1'b0;
        res_rd_en  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    img_we   = 1'b1;
                    ld_cnt_d = ld_cnt_q + 14'd1;
                    // Leave LOAD on the same edge that stores the final pixel.
                    if (ld_cnt_q == LAST_PIX) begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                gray_rd_en = gray_req;
                if (lbp_valid) begin
                    res_we = 1'b1;
                    if (wr_count_q != WR_MAX) begin
                        wr_count_d = wr_count_q + 15'd1;
                    end
                end
                // A write in the finishing cycle is still taken (res_we above).
                if (finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                res_rd_en = 1'b1;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ld_cnt_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (img_we) begin
            img[ld_cnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (res_we) begin
            res[lbp_addr] <= lbp_data;
        end
    end

    // Read registers hold their value whenever no read is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_data_q <= '0;
        end else if (gray_rd_en) begin
            gray_data_q <= img[gray_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (res_rd_en) begin
            rd_data_q <= res[rd_addr];
        end
    end

    assign gray_ready = (state_q == ST_SERVE);
    assign done       = (state_q == ST_DONE);
    assign gray_data  = gray_data_q;
    assign rd_data    = rd_data_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_lbp_host.sv
module tb_lbp_host;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [13:0] gray_addr;
    logic        gray_req;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic [14:0] wr_count;

    lbp_host dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .done       (done),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int n_wr     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = loading image, 1 = serving engine, 2 = finished
    logic [7:0] img_m [16384];
    bit         img_v [16384];
    logic [7:0] res_m [16384];
    bit         res_v [16384];
    int         m_phase;
    int         m_ld;
    int         m_wr;
    logic [7:0] m_gray;
    bit         m_gk;
    logic [7:0] m_rd;
    bit         m_rk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_ld    <= 0;
            m_wr    <= 0;
            m_gray  <= 8'h00;
            m_gk    <= 1'b1;
            m_rd    <= 8'h00;
            m_rk    <= 1'b1;
        end else begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    img_m[m_ld] <= in_data;
                    img_v[m_ld] <= 1'b1;
                    m_ld        <= (m_ld + 1) % 16384;
                    if (m_ld == 16383) m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (gray_req) begin
                    m_gray <= img_m[gray_addr];
                    m_gk   <= img_v[gray_addr];
                end
                if (lbp_valid) begin
                    res_m[lbp_addr] <= lbp_data;
                    res_v[lbp_addr] <= 1'b1;
                    m_wr            <= (m_wr < 16384) ? m_wr + 1 : 16384;
                end
                if (finish) m_phase <= 2;
            end else begin
                m_rd <= res_m[rd_addr];
                m_rk <= res_v[rd_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_gray_ready", 32'(gray_ready), 32'(m_phase == 1));
            check("cyc_done", 32'(done), 32'(m_phase == 2));
            check("cyc_wr_count", 32'(wr_count), 32'(m_wr));
            if (m_gk) check("cyc_gray_data", 32'(gray_data), 32'(m_gray));
            if (m_rk) check("cyc_rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        gray_addr = 14'h0;
        gray_req  = 1'b0;
        lbp_addr  = 14'h0;
        lbp_valid = 1'b0;
        lbp_data  = 8'h00;
        finish    = 1'b0;
        rd_addr   = 14'h0;
    endtask

    // Drive random activity on the engine-side inputs.
    task automatic rand_engine(input bit allow_finish);
        gray_req  = 1'($urandom_range(0, 1));
        gray_addr = 14'($urandom);
        lbp_valid = 1'($urandom_range(0, 1));
        lbp_addr  = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 15)) : 14'($urandom);
        lbp_data  = 8'($urandom);
        finish    = allow_finish ? 1'($urandom_range(0, 1)) : 1'b0;
        rd_addr   = 14'($urandom);
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom);
    endtask

    // Full image load; gapped inserts an idle cycle after every two pixels.
    task automatic load_img(input bit gapped, input bit rnd_data);
        for (int i = 0; i < 16384; i++) begin
            if (gapped && (i % 2 == 0) && (i != 0)) begin
                rand_engine(1'b1);
                in_valid = 1'b0;
                tick();
            end
            if (i == 16383) check("ready_before_last", 32'(gray_ready), 32'd0);
            idle();
            in_valid = 1'b1;
            in_data  = rnd_data ? 8'($urandom) : 8'(i);
            tick();
        end
        idle();
        check("ready_after_last", 32'(gray_ready), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        idle();
        #1 reset = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_gray_ready", 32'(gray_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_gray_data", 32'(gray_data), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        tick();

        // Result write, finish and read request during LOAD are ignored.
        lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'hAA;
        finish = 1'b1; gray_req = 1'b1;
        tick();
        idle();
        check("load_lbp_ignored", 32'(wr_count), 32'd0);

        // Partial load, then reset mid-LOAD.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 ^ 8'(i);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_rst_ready", 32'(gray_ready), 32'd0);

        // Gapped ramp load.
        load_img(1'b1, 1'b0);

        // Fresh image content after the aborted load.
        gray_req = 1'b1; gray_addr = 14'd1;
        tick();
        check("rd_img1", 32'(gray_data), 32'h01);
        gray_addr = 14'd0;
        tick();
        check("rd_img0_new", 32'(gray_data), 32'h00);

        // Back-to-back reads then hold.
        gray_addr = 14'h0081; tick(); check("b2b_81", 32'(gray_data), 32'h81);
        gray_addr = 14'h0082; tick(); check("b2b_82", 32'(gray_data), 32'h82);
        gray_addr = 14'h0083; tick(); check("b2b_83", 32'(gray_data), 32'h83);
        gray_req = 1'b0; gray_addr = 14'h0010;
        tick(); check("hold_83_a", 32'(gray_data), 32'h83);
        tick(); check("hold_83_b", 32'(gray_data), 32'h83);

        // Random serving traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_engine(1'b0);
            if (lbp_valid) n_wr++;
            tick();
        end
        idle();
        check("serve_wr_count", 32'(wr_count), 32'(n_wr));

        lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'h33;
        n_wr++;
        tick();

        // Write, read and finish in the same cycle.
        lbp_valid = 1'b1; lbp_addr = 14'h3FFF; lbp_data = 8'h5A;
        finish = 1'b1; gray_req = 1'b1; gray_addr = 14'h0081;
        n_wr++;
        tick();
        idle();
        check("fin_wr_count", 32'(wr_count), 32'(n_wr));
        check("fin_done", 32'(done), 32'd1);
        check("fin_gray_ready", 32'(gray_ready), 32'd0);
        check("fin_gray_data", 32'(gray_data), 32'h81);

        // In DONE everything except readout is ignored.
        rd_addr = 14'd5;
        lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'hAA;
        in_valid = 1'b1; finish = 1'b1; gray_req = 1'b1; gray_addr = 14'h0082;
        tick();
        idle();
        check("done_res5", 32'(rd_data), 32'h33);
        check("done_gray_hold", 32'(gray_data), 32'h81);
        check("done_wr_hold", 32'(wr_count), 32'(n_wr));
        rd_addr = 14'd5;
        tick();
        check("done_res5_again", 32'(rd_data), 32'h33);
        rd_addr = 14'h3FFF;
        tick();
        check("done_res3fff", 32'(rd_data), 32'h5A);
        for (int i = 0; i < 500; i++) begin
            rand_engine(1'b1);
            tick();
        end
        idle();
        check("done_sticky", 32'(done), 32'd1);

        // Session B: reset out of DONE, random reload, saturate the counter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstB_done", 32'(done), 32'd0);
        check("rstB_wr_count", 32'(wr_count), 32'd0);
        load_img(1'b0, 1'b1);
        for (int i = 0; i <= 16384; i++) begin
            gray_req  = 1'($urandom_range(0, 1));
            gray_addr = 14'($urandom);
            lbp_valid = 1'b1;
            lbp_addr  = 14'(i);
            lbp_data  = 8'($urandom);
            tick();
            if (i == 16383) check("sat_at_16384", 32'(wr_count), 32'd16384);
        end
        idle();
        check("sat_hold", 32'(wr_count), 32'd16384);
        finish = 1'b1;
        tick();
        idle();
        check("finB_done", 32'(done), 32'd1);
        for (int i = 0; i < 300; i++) begin
            rand_engine(1'b1);
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
